// File: rtl/exe_decode.sv
// Purpose : decode stage turning a 32-bit instruction into ALU command, operands and destination.
// Latency : 1 cycle from accepted instruction to a valid ID/EX slot, throughput 1 per cycle.
// Backpr. : in_ready drops when the slot is full and not drained, on a RAW hazard, or on flush.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      instruction handshake, instr is the offered word
//   rs_addr/rt_addr        combinational register-file read addresses
//   rs_data/rt_data        register-file read data, same cycle
//   flush                  kills the held slot and the instruction on offer
//   out_valid/out_ready    ID/EX slot handshake towards EX
//   exe_cmd, val1, val2    ALU command and operands
//   wr_en, wr_rd           destination write enable and register
//   illegal                slot holds an undecodable instruction (a bubble)
//   wb_valid, wb_rd        write-back retire, clears the busy bit of wb_rd
// Optional: `define EXE_DECODE_ILL_CNT_EN adds ill_cnt[15:0], a saturating count of
//   illegal instructions handed to EX.
module exe_decode #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  output logic [4:0]    rs_addr,
  output logic [4:0]    rt_addr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    exe_cmd,
  output logic [DW-1:0] val1,
  output logic [DW-1:0] val2,
  output logic          wr_en,
  output logic [4:0]    wr_rd,
  output logic          illegal,
  input  logic          wb_valid,
  input  logic [4:0]    wb_rd
`ifdef EXE_DECODE_ILL_CNT_EN
  ,
  output logic [15:0]   ill_cnt
`endif
);

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_AND = 4'd2;
  localparam logic [3:0] CMD_OR  = 4'd3;
  localparam logic [3:0] CMD_NOR = 4'd4;
  localparam logic [3:0] CMD_XOR = 4'd5;
  localparam logic [3:0] CMD_SLA = 4'd6;
  localparam logic [3:0] CMD_SLL = 4'd7;
  localparam logic [3:0] CMD_SRA = 4'd8;
  localparam logic [3:0] CMD_SRL = 4'd9;

  // instruction fields
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  assign rs_addr = rs;
  assign rt_addr = rt;

  // decoded values for the instruction on offer
  logic [3:0]    dec_cmd;
  logic [DW-1:0] dec_v1;
  logic [DW-1:0] dec_v2;
  logic [4:0]    dec_dest;
  logic          dec_legal;
  logic          dec_we;
  logic          dec_shift;
  logic          rt_src;

  // slot state
  logic          out_valid_q, out_valid_d;
  logic [3:0]    exe_cmd_q,   exe_cmd_d;
  logic [DW-1:0] val1_q,      val1_d;
  logic [DW-1:0] val2_q,      val2_d;
  logic          wr_en_q,     wr_en_d;
  logic [4:0]    wr_rd_q,     wr_rd_d;
  logic          illegal_q,   illegal_d;
  logic [NREG-1:0] busy_q,    busy_d;

  logic rs_busy, rt_busy, rs_slot, rt_slot, hazard;
  logic load, handoff;

  always_comb begin
    dec_cmd   = CMD_ADD;
    dec_v1    = '0;
    dec_v2    = '0;
    dec_dest  = 5'd0;
    dec_legal = 1'b0;
    dec_shift = 1'b0;
    if (op == 6'h00) begin
      dec_legal = 1'b1;
      case (funct)
        6'h20: dec_cmd = CMD_ADD;
        6'h22: dec_cmd = CMD_SUB;
        6'h24: dec_cmd = CMD_AND;
        6'h25: dec_cmd = CMD_OR;
        6'h27: dec_cmd = CMD_NOR;
        6'h26: dec_cmd = CMD_XOR;
        6'h01: begin dec_cmd = CMD_SLA; dec_shift = 1'b1; end
        6'h00: begin dec_cmd = CMD_SLL; dec_shift = 1'b1; end
        6'h03: begin dec_cmd = CMD_SRA; dec_shift = 1'b1; end
        6'h02: begin dec_cmd = CMD_SRL; dec_shift = 1'b1; end
        default: dec_legal = 1'b0;
      endcase
      if (dec_legal) begin
        dec_v1   = rs_data;
        dec_v2   = dec_shift ? {{(DW-5){1'b0}}, shamt} : rt_data;
        dec_dest = rd;
      end
    end else begin
      dec_legal = 1'b1;
      case (op)
        6'h08: begin dec_cmd = CMD_ADD; dec_v2 = {{(DW-16){imm[15]}}, imm}; end
        6'h0C: begin dec_cmd = CMD_AND; dec_v2 = {{(DW-16){1'b0}}, imm}; end
        6'h0D: begin dec_cmd = CMD_OR;  dec_v2 = {{(DW-16){1'b0}}, imm}; end
        6'h0E: begin dec_cmd = CMD_XOR; dec_v2 = {{(DW-16){1'b0}}, imm}; end
        default: dec_legal = 1'b0;
      endcase
      if (dec_legal) begin
        dec_v1   = rs_data;
        dec_dest = rt;
      end
    end
    // undecodable words travel as ADD bubbles with zero operands
    if (!dec_legal) begin
      dec_cmd = CMD_ADD;
      dec_v2  = '0;
    end
    dec_we = dec_legal & (dec_dest != 5'd0);
    rt_src = (op == 6'h00) & dec_legal & ~dec_shift;
  end

  // RAW hazard check; a busy bit being retired this very cycle is already safe to read
  always_comb begin
    rs_busy = busy_q[rs] & ~(wb_valid & (wb_rd == rs));
    rt_busy = busy_q[rt] & ~(wb_valid & (wb_rd == rt));
    rs_slot = out_valid_q & wr_en_q & (wr_rd_q == rs);
    rt_slot = out_valid_q & wr_en_q & (wr_rd_q == rt);
    hazard  = ((rs != 5'd0) & (rs_busy | rs_slot)) |
              (rt_src & (rt != 5'd0) & (rt_busy | rt_slot));
  end

  assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
  assign load     = in_valid & in_ready;
  assign handoff  = out_valid_q & out_ready & ~flush;

  always_comb begin
    out_valid_d = out_valid_q;
    exe_cmd_d   = exe_cmd_q;
    val1_d      = val1_q;
    val2_d      = val2_q;
    wr_en_d     = wr_en_q;
    wr_rd_d     = wr_rd_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      exe_cmd_d   = dec_cmd;
      val1_d      = dec_v1;
      val2_d      = dec_v2;
      wr_en_d     = dec_we;
      wr_rd_d     = dec_dest;
      illegal_d   = ~dec_legal;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end
  end

  // clear first so that a same-cycle set of the same register wins
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (handoff & wr_en_q) busy_d[wr_rd_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      exe_cmd_q   <= CMD_ADD;
      val1_q      <= '0;
      val2_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_rd_q     <= 5'd0;
      illegal_q   <= 1'b0;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      exe_cmd_q   <= exe_cmd_d;
      val1_q      <= val1_d;
      val2_q      <= val2_d;
      wr_en_q     <= wr_en_d;
      wr_rd_q     <= wr_rd_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign exe_cmd   = exe_cmd_q;
  assign val1      = val1_q;
  assign val2      = val2_q;
  assign wr_en     = wr_en_q;
  assign wr_rd     = wr_rd_q;
  assign illegal   = illegal_q;

`ifdef EXE_DECODE_ILL_CNT_EN
  logic [15:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (handoff & illegal_q & (ill_cnt_q != 16'hFFFF)) ill_cnt_d = ill_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_cnt_q <= 16'd0;
    else        ill_cnt_q <= ill_cnt_d;
  end

  assign ill_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_exe_decode.sv
// Purpose : scoreboard bench for exe_decode with directed, hand-computed vectors.
// Latency : expects each accepted instruction in the ID/EX slot one cycle later.
// Backpr. : exercises hazard stalls, out_ready holds, flush and async reset.
module tb_exe_decode;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        we;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  exe_cmd;
  logic [31:0] val1;
  logic [31:0] val2;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
`ifdef EXE_DECODE_ILL_CNT_EN
  logic [15:0] ill_cnt;
`endif

  exe_decode #(.DW(32), .NREG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exe_cmd   (exe_cmd),
    .val1      (val1),
    .val2      (val2),
    .wr_en     (wr_en),
    .wr_rd     (wr_rd),
    .illegal   (illegal),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd)
`ifdef EXE_DECODE_ILL_CNT_EN
    ,
    .ill_cnt   (ill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk_e(input logic [3:0] c, input logic [31:0] v1, input logic [31:0] v2,
                                input logic we, input logic [4:0] rd, input logic ill);
    exp_t e;
    e.cmd = c; e.v1 = v1; e.v2 = v2; e.we = we; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                              input exp_t e);
    vec_t v;
    v.ins = ins; v.a = a; v.b = b; v.e = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the offer until accepted (bounded) and returns at posedge+1.
  task automatic offer(input vec_t v, output int tries);
    logic acc;
    tries = 0;
    acc = 1'b0;
    in_valid = 1'b1; instr = v.ins; rs_data = v.a; rt_data = v.b;
    while (!acc && tries < 20) begin
      @(negedge clk);
      tries++;
      acc = in_ready;
      if (acc) sb.push_back(v.e);
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      errors++; checks++;
      $display("FAIL accept_timeout: instr %h not accepted after %0d cycles", v.ins, tries);
    end
  endtask

  // Monitor: every handoff is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL sb_underflow: handoff with cmd %h but no expected entry", exe_cmd);
      end else begin
        mon_e = sb.pop_front();
        chk("exe_cmd", {28'd0, exe_cmd}, {28'd0, mon_e.cmd});
        chk("val1",    val1,             mon_e.v1);
        chk("val2",    val2,             mon_e.v2);
        chk("wr_en",   {31'd0, wr_en},   {31'd0, mon_e.we});
        chk("wr_rd",   {27'd0, wr_rd},   {27'd0, mon_e.rd});
        chk("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
      end
    end
  end

  initial begin : stim
    int   t;
    vec_t vx, vy, vz;

    tbl[0]  = mk(32'h00221820, 32'd5,  32'd7,  mk_e(4'd0, 32'd5,  32'd7,        1'b1, 5'd3,  1'b0));
    tbl[1]  = mk(32'h2004FFFF, 32'd0,  32'd0,  mk_e(4'd0, 32'd0,  32'hFFFFFFFF, 1'b1, 5'd4,  1'b0));
    tbl[2]  = mk(32'h3004FFFF, 32'd0,  32'd0,  mk_e(4'd2, 32'd0,  32'h0000FFFF, 1'b1, 5'd4,  1'b0));
    tbl[3]  = mk(32'h00223103, 32'd9,  32'h80, mk_e(4'd8, 32'd9,  32'd4,        1'b1, 5'd6,  1'b0));
    tbl[4]  = mk(32'h00223822, 32'd10, 32'd3,  mk_e(4'd1, 32'd10, 32'd3,        1'b1, 5'd7,  1'b0));
    tbl[5]  = mk(32'h00224024, 32'hF0F0, 32'hFF00, mk_e(4'd2, 32'hF0F0, 32'hFF00, 1'b1, 5'd8, 1'b0));
    tbl[6]  = mk(32'h00224825, 32'h1,  32'h2,  mk_e(4'd3, 32'h1,  32'h2,        1'b1, 5'd9,  1'b0));
    tbl[7]  = mk(32'h00225027, 32'h3,  32'h4,  mk_e(4'd4, 32'h3,  32'h4,        1'b1, 5'd10, 1'b0));
    tbl[8]  = mk(32'h00225826, 32'h5,  32'h6,  mk_e(4'd5, 32'h5,  32'h6,        1'b1, 5'd11, 1'b0));
    tbl[9]  = mk(32'h00226041, 32'h7,  32'h8,  mk_e(4'd6, 32'h7,  32'd1,        1'b1, 5'd12, 1'b0));
    tbl[10] = mk(32'h00226FC0, 32'h9,  32'hA,  mk_e(4'd7, 32'h9,  32'd31,       1'b1, 5'd13, 1'b0));
    tbl[11] = mk(32'h00227002, 32'hB,  32'hC,  mk_e(4'd9, 32'hB,  32'd0,        1'b1, 5'd14, 1'b0));
    tbl[12] = mk(32'h342F8001, 32'h11, 32'h22, mk_e(4'd3, 32'h11, 32'h00008001, 1'b1, 5'd15, 1'b0));
    tbl[13] = mk(32'h38301234, 32'h33, 32'h44, mk_e(4'd5, 32'h33, 32'h00001234, 1'b1, 5'd16, 1'b0));
    tbl[14] = mk(32'h20317FFF, 32'h55, 32'h66, mk_e(4'd0, 32'h55, 32'h00007FFF, 1'b1, 5'd17, 1'b0));
    tbl[15] = mk(32'h00220020, 32'h77, 32'h88, mk_e(4'd0, 32'h77, 32'h88,       1'b0, 5'd0,  1'b0));
    tbl[16] = mk(32'hFC221820, 32'h99, 32'hAA, mk_e(4'd0, 32'd0,  32'd0,        1'b0, 5'd0,  1'b1));
    tbl[17] = mk(32'h0022183F, 32'hBB, 32'hCC, mk_e(4'd0, 32'd0,  32'd0,        1'b0, 5'd0,  1'b1));

    in_valid = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    flush = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_exe_cmd",   {28'd0, exe_cmd},   32'd0);
    chk("rst_val1",      val1,               32'd0);
    chk("rst_val2",      val2,               32'd0);
    chk("rst_wr_en",     {31'd0, wr_en},     32'd0);
    chk("rst_wr_rd",     {27'd0, wr_rd},     32'd0);
    chk("rst_illegal",   {31'd0, illegal},   32'd0);
`ifdef EXE_DECODE_ILL_CNT_EN
    chk("rst_ill_cnt",   {16'd0, ill_cnt},   32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // decode table back to back: each must be taken on its first offer
    for (int i = 0; i < 18; i++) begin
      offer(tbl[i], t);
      chk("throughput_tries", t, 32'd1);
    end
    tick();
    tick();
`ifdef EXE_DECODE_ILL_CNT_EN
    chk("ill_cnt_after_table", {16'd0, ill_cnt}, 32'd2);
`endif

    // retire every register so the scoreboard starts clean
    for (int r = 1; r < 32; r++) begin
      wb_valid = 1'b1; wb_rd = r[4:0];
      tick();
    end
    wb_valid = 1'b0;

    // RAW on r3: stalled by the slot, then by the busy bit, released by write-back
    offer(tbl[0], t);
    vz = mk(32'h00612822, 32'd20, 32'd6, mk_e(4'd1, 32'd20, 32'd6, 1'b1, 5'd5, 1'b0));
    in_valid = 1'b1; instr = vz.ins; rs_data = vz.a; rt_data = vz.b;
    @(negedge clk); chk("raw_slot_stall", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk); chk("raw_busy_stall1", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk); chk("raw_busy_stall2", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk); chk("raw_wb_release", {31'd0, in_ready}, 32'd1);
    if (in_ready) sb.push_back(vz.e);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    tick();

    // busy set and clear of r3 in the same cycle: set wins
    offer(tbl[0], t);
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b1; instr = vz.ins; rs_data = vz.a; rt_data = vz.b;
    @(negedge clk); chk("set_wins_stall", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk); chk("set_wins_release", {31'd0, in_ready}, 32'd1);
    if (in_ready) sb.push_back(vz.e);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    tick();

    // full slot held by out_ready=0 for 3 cycles
    vx = mk(32'h00223822, 32'd10, 32'd3, mk_e(4'd1, 32'd10, 32'd3, 1'b1, 5'd7, 1'b0));
    vy = mk(32'h00224825, 32'hF0, 32'h0F, mk_e(4'd3, 32'hF0, 32'h0F, 1'b1, 5'd9, 1'b0));
    out_ready = 1'b0;
    offer(vx, t);
    in_valid = 1'b1; instr = vy.ins; rs_data = vy.a; rt_data = vy.b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_exe_cmd",   {28'd0, exe_cmd},   32'd1);
      chk("hold_val1",      val1,               32'd10);
      chk("hold_val2",      val2,               32'd3);
      chk("hold_wr_rd",     {27'd0, wr_rd},     32'd7);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk); chk("hold_release", {31'd0, in_ready}, 32'd1);
    if (in_ready) sb.push_back(vy.e);
    tick();
    in_valid = 1'b0;
    tick();

    // flush with a full slot and a valid offer; r5 stays busy, r20 never becomes busy
    vx = mk(32'h0022A020, 32'd1, 32'd2, mk_e(4'd0, 32'd1, 32'd2, 1'b1, 5'd20, 1'b0));
    out_ready = 1'b0;
    offer(vx, t);
    in_valid = 1'b1; instr = 32'h00225826; rs_data = 32'd5; rt_data = 32'd6;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_sb_has_slot", sb.size(), 32'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    tick();
    flush = 1'b0; in_valid = 1'b0;
    instr = 32'h0280A820;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_r20_not_busy", {31'd0, in_ready}, 32'd1);
    instr = 32'h00A0B020;
    #1 chk("flush_r5_still_busy", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();

`ifdef EXE_DECODE_ILL_CNT_EN
    // drive the illegal counter to saturation and one past it
    for (int n = 0; n < 65533; n++) offer(tbl[16], t);
    tick();
    tick();
    chk("ill_cnt_at_max", {16'd0, ill_cnt}, 32'h0000FFFF);
    offer(tbl[17], t);
    tick();
    tick();
    chk("ill_cnt_saturate", {16'd0, ill_cnt}, 32'h0000FFFF);
`endif

    // asynchronous reset with a full slot and busy r5
    out_ready = 1'b0;
    offer(tbl[4], t);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_exe_cmd",   {28'd0, exe_cmd},   32'd0);
    chk("arst_val1",      val1,               32'd0);
    chk("arst_wr_en",     {31'd0, wr_en},     32'd0);
    chk("arst_wr_rd",     {27'd0, wr_rd},     32'd0);
    sb.delete();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    instr = 32'h00A0B020;
    @(negedge clk); chk("arst_busy_cleared", {31'd0, in_ready}, 32'd1);
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
